tsmp_forward_table_arbiter: RTL
===============================

# tsmp_forward_table_arbiter

Shares the single-port TSMP forward table RAM between two requesters: the configuration path (command parser, no backpressure) and the packet lookup path (forwarding engine, request/ack). Lookups take priority. Configuration has a starvation guard and a one-entry holding slot. The block sits between both requesters and the RAM, drives all RAM control, and routes tagged read data back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 12, RAM address width (4096 entries).
- DATA_W, 34, RAM entry width.
- RAM_RD_LAT, 2, cycles from registered o_ram_rd to valid iv_ram_rdata.
- STARVE_MAX, 8, wait cycles after which a pending config op beats lookups.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cfg_wr  in  1  config write strobe, one cycle.
- i_cfg_rd  in  1  config read strobe, one cycle.
- iv_cfg_addr  in  ADDR_W  config address.
- iv_cfg_wdata  in  DATA_W  config write data.
- o_cfg_ready  out  1  holding slot empty, registered.
- ov_cfg_rdata  out  DATA_W  config read data.
- o_cfg_rdata_valid  out  1  one-cycle pulse qualifying ov_cfg_rdata.
- o_cfg_overflow  out  1  one-cycle pulse: strobe dropped because the slot was full.
- i_lkp_req  in  1  lookup request, level; held until acked.
- iv_lkp_addr  in  ADDR_W  lookup address, stable while i_lkp_req is high.
- o_lkp_ack  out  1  combinational grant.
- ov_lkp_rdata  out  DATA_W  lookup read data.
- o_lkp_rdata_valid  out  1  one-cycle pulse.
- ov_ram_addr  out  ADDR_W  registered.
- ov_ram_wdata  out  DATA_W  registered.
- o_ram_wr  out  1  registered.
- o_ram_rd  out  1  registered.
- iv_ram_rdata  in  DATA_W  RAM read data.
- ov_cfg_stall_cnt  out  16  saturating count of cycles a pending config op lost arbitration.

## Operation
**Config capture**
- When o_cfg_ready=1 and (i_cfg_wr | i_cfg_rd), the block latches op, addr and wdata into the slot. The slot becomes pending.
- If both strobes are high in the same cycle, the write is taken and the read is discarded.
- A strobe while the slot is pending is dropped, and o_cfg_overflow pulses on the next cycle.

**Arbitration** (evaluated every cycle)
- Config wins when the slot is pending and either i_lkp_req=0 or starve_cnt==STARVE_MAX.
- In all other cases a lookup request wins.
- o_lkp_ack = i_lkp_req & ~cfg_win.

**Starvation counter**
- starve_cnt (width ceil(log2(STARVE_MAX+1))) increments when the slot is pending and a lookup wins.
- It clears on a config grant and does not exceed STARVE_MAX.
- ov_cfg_stall_cnt increments in the same cycles starve_cnt does, and saturates at 0xFFFF.

**Issue**
- A grant in cycle T drives ov_ram_addr, ov_ram_wdata, o_ram_wr and o_ram_rd in T+1.
- Idle cycles drive o_ram_wr=0, o_ram_rd=0 and ov_ram_addr=0. ov_ram_wdata holds its value.
- A config grant frees the slot, so o_cfg_ready=1 from T+1.
- A new strobe in the grant cycle T itself is still dropped, because o_cfg_ready is registered.

**Return path**
- A tag shift register of depth RAM_RD_LAT+1 carries {valid, owner} alongside each read.
- When the tag exits, iv_ram_rdata is registered into the owner's rdata bus, with the matching valid pulse.
- The other requester's rdata bus holds its previous value.
- Writes generate no return.

**Ordering**
- RAM accesses occur in grant order.
- A lookup granted after a config write to the same address returns the new data.

## Timing
**Reset values**
- All registered outputs are 0, except o_cfg_ready=1.
- The slot, starve_cnt, ov_cfg_stall_cnt and the tag pipeline are cleared.

**Reset mid-operation**
- In-flight reads are discarded; no rdata_valid appears after reset deasserts.
- A pending config op is lost.

**Latency**
- Read data is valid at T+2+RAM_RD_LAT after the grant cycle T. This is T+4 with defaults.
- Lookup back-to-back throughput is one read per cycle.

**Config worst-case wait**
- Under continuous lookups a pending config op waits STARVE_MAX cycles.
- It is granted on the (STARVE_MAX+1)-th pending cycle.

**Simultaneous events**
- Grant and capture in the same cycle is impossible, because o_cfg_ready is low while the slot is pending.
- Both strobes high: write taken, read dropped, no overflow pulse.

## Test plan
- **Idle config write then read:** cfg_wr addr 0x005 data 0x3_0000_00AA, then cfg_rd 0x005 three cycles later -> o_ram_wr one cycle after capture+1; o_cfg_rdata_valid with 0x3_0000_00AA at rd grant +4.
- **Continuous lookup plus pending config:** i_lkp_req held high for 20 cycles, cfg_rd at cycle 2 -> o_lkp_ack low for exactly one cycle, 9 cycles after capture; ov_cfg_stall_cnt=8; config data returned to the config port only.
- **Overflow:** two cfg_wr strobes on consecutive cycles while lookups hold the RAM -> o_cfg_overflow pulses once; only the first write reaches the RAM.
- **Interleaved tags:** alternating lookup and config reads to addresses 0x001 and 0x002 preloaded with distinct data -> each read's data appears only on its owner's port; no cross-routing; valids in issue order.
- **Write-then-lookup coherence:** cfg_wr addr 0x010, then lookup 0x010 granted the next cycle -> ov_lkp_rdata equals the new data.
- **Reset mid-read:** assert i_rst_n=0 one cycle after a lookup grant -> all outputs take reset values, o_cfg_ready=1, and no rdata_valid after release.

Source files
------------

// File: rtl/tsmp_forward_table_arbiter.sv
`default_nettype none
// tsmp_forward_table_arbiter: single-port forward table RAM shared between the config path
// (one-entry holding slot, starvation guard) and the lookup path (priority, request/ack).
module tsmp_forward_table_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 34,
  parameter int RAM_RD_LAT = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_wr,
  input  logic              i_cfg_rd,
  input  logic [ADDR_W-1:0] iv_cfg_addr,
  input  logic [DATA_W-1:0] iv_cfg_wdata,
  output logic              o_cfg_ready,
  output logic [DATA_W-1:0] ov_cfg_rdata,
  output logic              o_cfg_rdata_valid,
  output logic              o_cfg_overflow,
  input  logic              i_lkp_req,
  input  logic [ADDR_W-1:0] iv_lkp_addr,
  output logic              o_lkp_ack,
  output logic [DATA_W-1:0] ov_lkp_rdata,
  output logic              o_lkp_rdata_valid,
  output logic [ADDR_W-1:0] ov_ram_addr,
  output logic [DATA_W-1:0] ov_ram_wdata,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  input  logic [DATA_W-1:0] iv_ram_rdata,
  output logic [15:0]       ov_cfg_stall_cnt
);

  localparam int                  STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam int                  TAG_D      = RAM_RD_LAT + 1;

  logic                slot_wr;
  logic [ADDR_W-1:0]   slot_addr;
  logic [DATA_W-1:0]   slot_wdata;
  logic [STARVE_W-1:0] starve_cnt;
  logic [TAG_D-1:0]    tag_vld;
  logic [TAG_D-1:0]    tag_cfg;
  logic                cfg_strobe;
  logic                capture;
  logic                cfg_win;
  logic                lkp_win;
  logic                rd_issue;

  // o_cfg_ready low is exactly "slot pending", so it doubles as the pending flag.
  assign cfg_strobe = i_cfg_wr | i_cfg_rd;
  assign capture    = o_cfg_ready & cfg_strobe;
  assign cfg_win    = ~o_cfg_ready & (~i_lkp_req | (starve_cnt == STARVE_LIM));
  assign lkp_win    = i_lkp_req & ~cfg_win;
  assign o_lkp_ack  = lkp_win;
  assign rd_issue   = lkp_win | (cfg_win & ~slot_wr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cfg_ready    <= 1'b1;
      o_cfg_overflow <= 1'b0;
      slot_wr        <= 1'b0;
      slot_addr      <= '0;
      slot_wdata     <= '0;
    end else begin
      o_cfg_overflow <= cfg_strobe & ~o_cfg_ready;
      if (capture) begin
        o_cfg_ready <= 1'b0;
        slot_wr     <= i_cfg_wr;
        slot_addr   <= iv_cfg_addr;
        slot_wdata  <= iv_cfg_wdata;
      end else if (cfg_win) begin
        o_cfg_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt       <= '0;
      ov_cfg_stall_cnt <= '0;
    end else if (cfg_win) begin
      starve_cnt <= '0;
    end else if (~o_cfg_ready & lkp_win) begin
      if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
      if (ov_cfg_stall_cnt != 16'hFFFF) ov_cfg_stall_cnt <= ov_cfg_stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ram_wr     <= 1'b0;
      o_ram_rd     <= 1'b0;
      ov_ram_addr  <= '0;
      ov_ram_wdata <= '0;
    end else begin
      o_ram_wr <= cfg_win & slot_wr;
      o_ram_rd <= rd_issue;
      if (cfg_win)      ov_ram_addr <= slot_addr;
      else if (lkp_win) ov_ram_addr <= iv_lkp_addr;
      else              ov_ram_addr <= '0;
      if (cfg_win & slot_wr) ov_ram_wdata <= slot_wdata;
    end
  end

  // Tag stage 0 lines up with o_ram_rd; the last stage lines up with valid RAM data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_vld           <= '0;
      tag_cfg           <= '0;
      o_cfg_rdata_valid <= 1'b0;
      o_lkp_rdata_valid <= 1'b0;
      ov_cfg_rdata      <= '0;
      ov_lkp_rdata      <= '0;
    end else begin
      tag_vld           <= {tag_vld[TAG_D-2:0], rd_issue};
      tag_cfg           <= {tag_cfg[TAG_D-2:0], cfg_win};
      o_cfg_rdata_valid <= tag_vld[TAG_D-1] & tag_cfg[TAG_D-1];
      o_lkp_rdata_valid <= tag_vld[TAG_D-1] & ~tag_cfg[TAG_D-1];
      if (tag_vld[TAG_D-1] & tag_cfg[TAG_D-1])  ov_cfg_rdata <= iv_ram_rdata;
      if (tag_vld[TAG_D-1] & ~tag_cfg[TAG_D-1]) ov_lkp_rdata <= iv_ram_rdata;
    end
  end

endmodule
`default_nettype wire
